// File: rtl/register_bank.sv
// Architectural register storage for the EV22 core: 35-entry register map,
// main and Working_Register write ports, synchronized input ports and change pulse.
module register_bank #(
    parameter int                 DATA_W    = 16,
    parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Wr_En,
    input  logic [5:0]        Wr_Sel,
    input  logic [DATA_W-1:0] Wr_Data,
    input  logic              W_Wr_En,
    input  logic [DATA_W-1:0] W_Wr_Data,
    input  logic [DATA_W-1:0] PI0_In,
    input  logic [DATA_W-1:0] PI1_In,
    output logic [DATA_W-1:0] r0,
    output logic [DATA_W-1:0] r1,
    output logic [DATA_W-1:0] r2,
    output logic [DATA_W-1:0] r3,
    output logic [DATA_W-1:0] r4,
    output logic [DATA_W-1:0] r5,
    output logic [DATA_W-1:0] r6,
    output logic [DATA_W-1:0] r7,
    output logic [DATA_W-1:0] r8,
    output logic [DATA_W-1:0] r9,
    output logic [DATA_W-1:0] r10,
    output logic [DATA_W-1:0] r11,
    output logic [DATA_W-1:0] r12,
    output logic [DATA_W-1:0] r13,
    output logic [DATA_W-1:0] r14,
    output logic [DATA_W-1:0] r15,
    output logic [DATA_W-1:0] r16,
    output logic [DATA_W-1:0] r17,
    output logic [DATA_W-1:0] r18,
    output logic [DATA_W-1:0] r19,
    output logic [DATA_W-1:0] r20,
    output logic [DATA_W-1:0] r21,
    output logic [DATA_W-1:0] r22,
    output logic [DATA_W-1:0] r23,
    output logic [DATA_W-1:0] r24,
    output logic [DATA_W-1:0] r25,
    output logic [DATA_W-1:0] r26,
    output logic [DATA_W-1:0] r27,
    output logic [DATA_W-1:0] r28,
    output logic [DATA_W-1:0] r29,
    output logic [DATA_W-1:0] Output_Port_0,
    output logic [DATA_W-1:0] Output_Port_1,
    output logic [DATA_W-1:0] r32,
    output logic [DATA_W-1:0] r33,
    output logic [DATA_W-1:0] Working_Register,
    output logic              updateBlock,
    output logic              Wr_Err
);

    localparam int NUM_REGS = 35;

    // Slots 28/29 hold the second synchronizer stage so r28/r29 share the map.
    logic [DATA_W-1:0] bank_reg  [0:NUM_REGS-1];
    logic [DATA_W-1:0] bank_next [0:NUM_REGS-1];
    logic [DATA_W-1:0] sync1_reg [0:1];
    logic [DATA_W-1:0] hist_reg  [0:1];
    logic [1:0]        settle_reg;
    logic              update_reg;
    logic              wr_err_reg;

    logic wr_ok;
    logic pi_change;
    logic pi_event;

    assign wr_ok = Wr_En && ((Wr_Sel <= 6'd27) || ((Wr_Sel >= 6'd30) && (Wr_Sel <= 6'd34)));

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_next
            if (gi == 28) begin : g_pi0
                assign bank_next[gi] = sync1_reg[0];
            end else if (gi == 29) begin : g_pi1
                assign bank_next[gi] = sync1_reg[1];
            end else if (gi == 34) begin : g_wreg
                // Main port has priority over the dedicated Working_Register port.
                assign bank_next[gi] = (wr_ok && (Wr_Sel == 6'(gi))) ? Wr_Data :
                                       W_Wr_En                       ? W_Wr_Data :
                                                                       bank_reg[gi];
            end else begin : g_gpr
                assign bank_next[gi] = (wr_ok && (Wr_Sel == 6'(gi))) ? Wr_Data : bank_reg[gi];
            end
        end
    endgenerate

    assign pi_change = (bank_reg[28] != hist_reg[0]) || (bank_reg[29] != hist_reg[1]);
    // Input-port events are masked until the synchronizer and history have
    // flushed after reset, so release never produces a spurious pulse.
    assign pi_event  = pi_change && (settle_reg == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                bank_reg[i] <= RESET_VAL;
            end
            sync1_reg[0] <= RESET_VAL;
            sync1_reg[1] <= RESET_VAL;
            hist_reg[0]  <= RESET_VAL;
            hist_reg[1]  <= RESET_VAL;
            settle_reg   <= 2'd0;
            update_reg   <= 1'b0;
            wr_err_reg   <= 1'b0;
        end else begin
            bank_reg     <= bank_next;
            sync1_reg[0] <= PI0_In;
            sync1_reg[1] <= PI1_In;
            hist_reg[0]  <= bank_reg[28];
            hist_reg[1]  <= bank_reg[29];
            if (settle_reg != 2'd3) begin
                settle_reg <= settle_reg + 2'd1;
            end
            update_reg   <= wr_ok || W_Wr_En || pi_event;
            wr_err_reg   <= Wr_En && !wr_ok;
        end
    end

    assign r0  = bank_reg[0];
    assign r1  = bank_reg[1];
    assign r2  = bank_reg[2];
    assign r3  = bank_reg[3];
    assign r4  = bank_reg[4];
    assign r5  = bank_reg[5];
    assign r6  = bank_reg[6];
    assign r7  = bank_reg[7];
    assign r8  = bank_reg[8];
    assign r9  = bank_reg[9];
    assign r10 = bank_reg[10];
    assign r11 = bank_reg[11];
    assign r12 = bank_reg[12];
    assign r13 = bank_reg[13];
    assign r14 = bank_reg[14];
    assign r15 = bank_reg[15];
    assign r16 = bank_reg[16];
    assign r17 = bank_reg[17];
    assign r18 = bank_reg[18];
    assign r19 = bank_reg[19];
    assign r20 = bank_reg[20];
    assign r21 = bank_reg[21];
    assign r22 = bank_reg[22];
    assign r23 = bank_reg[23];
    assign r24 = bank_reg[24];
    assign r25 = bank_reg[25];
    assign r26 = bank_reg[26];
    assign r27 = bank_reg[27];
    assign r28 = bank_reg[28];
    assign r29 = bank_reg[29];
    assign Output_Port_0    = bank_reg[30];
    assign Output_Port_1    = bank_reg[31];
    assign r32              = bank_reg[32];
    assign r33              = bank_reg[33];
    assign Working_Register = bank_reg[34];
    assign updateBlock      = update_reg;
    assign Wr_Err           = wr_err_reg;

endmodule

// File: doc/register_bank.md
# register_bank

Architectural register storage for the EV22 core. It sits directly upstream of the operand-select stage and drives that stage's register inputs: r0–r27, r32, r33 and Working_Register (r34). It also drives the two output ports (r30/r31) and samples the two asynchronous input ports (r28/r29). It accepts one ALU/write-back write per cycle plus an independent Working_Register write. It pulses updateBlock whenever any value visible to operand select changes.

## Interface
Parameters:
- DATA_W, 16, register/port width
- RESET_VAL, 0, reset value of every storage register and output port

Ports:
- clk  input  1  core clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset; assertion clears state immediately, deassertion is synchronous to clk
- Wr_En  input  1  main write strobe, one write per cycle
- Wr_Sel  input  6  main write address (same encoding as operand select B)
- Wr_Data  input  DATA_W  main write data
- W_Wr_En  input  1  Working_Register dedicated write strobe
- W_Wr_Data  input  DATA_W  Working_Register dedicated write data
- PI0_In  input  DATA_W  asynchronous input port 0
- PI1_In  input  DATA_W  asynchronous input port 1
- r0 … r27  output  DATA_W each  general registers, address 0–27
- r28, r29  output  DATA_W each  synchronized PI0/PI1, read-only
- Output_Port_0, Output_Port_1  output  DATA_W each  address 30/31
- r32, r33  output  DATA_W each  address 32/33
- Working_Register  output  DATA_W  address 34
- updateBlock  output  1  one-cycle pulse: visible register contents changed
- Wr_Err  output  1  one-cycle pulse: rejected main write

## Operation
- Address map: 0–27 general, 28/29 PI (read-only), 30/31 output ports, 32/33 general, 34 Working_Register, 35–63 unmapped.
- Main write accepted when Wr_En=1 and Wr_Sel ∈ {0–27, 30–34}: target register ← Wr_Data. All other registers hold.
- Wr_En=1 with Wr_Sel ∈ {28, 29, 35–63}: no register changes; Wr_Err=1 the following cycle.
- W_Wr_En=1: Working_Register ← W_Wr_Data.
- Simultaneous W_Wr_En=1 and Wr_En=1 with Wr_Sel=34: main port wins; W_Wr_Data is discarded with no error.
- Simultaneous W_Wr_En and a main write to another address: both are performed.
- Input ports: each of PI0_In/PI1_In goes through a two-stage DATA_W-wide synchronizer. The second stage drives r28/r29.
- Input-port change detect: a third stage holds the previous synchronized value. A mismatch on either port counts as a change event.
- updateBlock: registered OR of (accepted main write) | (W_Wr_En) | (PI change event). Writing the same value as already stored still pulses. Rejected writes do not pulse.
- Reset (asynchronous, rst_n=0): all storage, output ports, synchronizer and history stages = RESET_VAL; updateBlock=0; Wr_Err=0. Writes presented during reset are lost. No updateBlock pulse is generated on reset release.

## Timing
- Write latency 1: data on Wr_Data at edge N appears on the target output after edge N. updateBlock is high during cycle N+1, aligned with the new value.
- Wr_Err is high during cycle N+1 for a rejected write at edge N.
- PI latency: a stable change on PI0_In before edge N is visible on r28 after edge N+1. The updateBlock pulse comes one cycle later, after edge N+2.
- Back-to-back writes every cycle are supported. updateBlock then stays high continuously, one pulse-cycle per event cycle.
- Outputs are purely registered. There is no combinational path from any input to any output.

## Test plan
- Reset: drive all inputs nonzero, pulse rst_n low mid-cycle -> every output 0x0000 immediately, updateBlock=0, Wr_Err=0. No pulse after release.
- Main write: Wr_Sel=5, Wr_Data=0xA5A5 at edge N -> r5=0xA5A5 and updateBlock=1 in cycle N+1, all other registers unchanged. Repeat for 30 -> Output_Port_0, 33 -> r33.
- Rejection: Wr_Sel=28 then Wr_Sel=40, each with Wr_Data=0xFFFF -> r28 and all storage unchanged, Wr_Err=1 one cycle after each, updateBlock=0.
- Collision: Wr_Sel=34, Wr_Data=0x1234 together with W_Wr_En, W_Wr_Data=0x5678 -> Working_Register=0x1234. Next cycle W_Wr_En alone with 0x00FF -> Working_Register=0x00FF, updateBlock high both cycles.
- PI sync: PI1_In 0x0000 -> 0xBEEF before edge N -> r29=0xBEEF after edge N+1, single updateBlock pulse after edge N+2. Holding PI1_In stable produces no further pulses.
- Burst: 30 consecutive writes to addresses 0–27, 32, 33 with data = address×0x0101 -> every register holds the expected value, updateBlock high for exactly 30 cycles.
